// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write-port arbiter: data width, parameter
// defaults and the IDLE/GRANT state encoding.
package fifo_arb_pkg;

    localparam int DATA_W        = 32;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_BURST = 16;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin search: first set request bit at or above the pointer, wrapping
// around; returns the one-hot winner and its index.
module rr_priority_select
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         request,
    input  logic [$clog2(NUM_REQ)-1:0] pointer,
    output logic [NUM_REQ-1:0]         winner,
    output logic [$clog2(NUM_REQ)-1:0] winnerIdx,
    output logic                       anyRequest
);

    localparam int PW = $clog2(NUM_REQ);

    int unsigned candidate;

    always_comb begin
        winner     = '0;
        winnerIdx  = '0;
        anyRequest = 1'b0;
        candidate  = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            candidate = 32'(pointer) + off;
            if (candidate >= NUM_REQ) begin
                candidate = candidate - NUM_REQ;
            end
            if (!anyRequest && request[candidate[PW-1:0]]) begin
                anyRequest                    = 1'b1;
                winner[candidate[PW-1:0]]     = 1'b1;
                winnerIdx                     = candidate[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ bursting
// requesters; bursts end on accepted last, MAX_BURST words, or request drop.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_request,
    input  logic [NUM_REQ-1:0]        i_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_data,
    input  logic [NUM_REQ-1:0]        i_last,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic [NUM_REQ-1:0]        o_accept,
    output logic [DATA_W-1:0]         o_fifoData,
    output logic                      o_fifoDataValid,
    input  logic                      i_fifoFull,
    output logic                      o_busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [0:0]         state;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      grantIdx;
    logic [PW-1:0]      pointer;
    logic [CW-1:0]      burstCount;

    logic [NUM_REQ-1:0] winner;
    logic [PW-1:0]      winnerIdx;
    logic               anyRequest;
    logic               inGrant;
    logic               transfer;
    logic               lastBeat;
    logic               burstEnd;
    logic [PW-1:0]      nextPointer;
    logic [DATA_W-1:0]  grantedData;

    rr_priority_select #(.NUM_REQ(NUM_REQ)) u_select (
        .request    (i_request),
        .pointer    (pointer),
        .winner     (winner),
        .winnerIdx  (winnerIdx),
        .anyRequest (anyRequest)
    );

    always_comb begin
        grantedData = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grantIdx == PW'(k)) begin
                grantedData = i_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign inGrant     = (state == ST_GRANT);
    assign transfer    = inGrant && i_request[grantIdx] && i_valid[grantIdx] && !i_fifoFull;
    assign lastBeat    = i_last[grantIdx] || (burstCount == CW'(MAX_BURST - 1));
    // A stalled cycle (full or not valid) with request still high never ends the burst.
    assign burstEnd    = inGrant && (transfer ? lastBeat : !i_request[grantIdx]);
    assign nextPointer = (grantIdx == PW'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            grant      <= '0;
            grantIdx   <= '0;
            pointer    <= '0;
            burstCount <= '0;
        end else if (!inGrant) begin
            if (anyRequest) begin
                state    <= ST_GRANT;
                grant    <= winner;
                grantIdx <= winnerIdx;
            end
        end else if (burstEnd) begin
            state      <= ST_IDLE;
            grant      <= '0;
            burstCount <= '0;
            pointer    <= nextPointer;
        end else if (transfer) begin
            burstCount <= burstCount + 1'b1;
        end
    end

    assign o_grant         = grant;
    assign o_accept        = transfer ? grant : '0;
    assign o_fifoDataValid = transfer;
    assign o_fifoData      = inGrant ? grantedData : '0;
    assign o_busy          = inGrant;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomised and directed bench for fifo_write_arbiter with a cycle-level
// behavioural model feeding an expectation queue checked by a monitor.
module tb_fifo_write_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, vld, lst;
    logic [N*32-1:0] dat;
    logic            full;
    logic [N-1:0]    o_grant, o_accept;
    logic [31:0]     o_fifoData;
    logic            o_fifoDataValid, o_busy;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.NUM_REQ(N), .MAX_BURST(MAXB)) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_request       (req),
        .i_valid         (vld),
        .i_data          (dat),
        .i_last          (lst),
        .o_grant         (o_grant),
        .o_accept        (o_accept),
        .o_fifoData      (o_fifoData),
        .o_fifoDataValid (o_fifoDataValid),
        .i_fifoFull      (full),
        .o_busy          (o_busy)
    );

    typedef struct packed {
        logic [N-1:0] g;
        logic [N-1:0] a;
        logic         b;
        logic         v;
        logic [31:0]  d;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] dataQ[$];
    int          obsOwners[$], obsLens[$], obsGaps[$];
    int          total = 0, bad = 0;
    int          owner = -1, ptr = 0, words = 0;
    logic        logB = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic endBurst();
        ptr   = (owner + 1) % N;
        owner = -1;
        words = 0;
    endtask

    // Advance the model across one clock edge using the inputs held during the cycle.
    task automatic modelStep();
        if (rst) begin
            owner = -1; ptr = 0; words = 0;
        end else if (owner >= 0) begin
            if (req[owner] && vld[owner] && !full) begin
                words++;
                if (lst[owner] || words == MAXB) endBurst();
            end else if (!req[owner]) begin
                endBurst();
            end
        end else if (req != '0) begin
            for (int off = 0; off < N; off++) begin
                if (req[(ptr + off) % N]) begin
                    owner = (ptr + off) % N;
                    break;
                end
            end
        end
    endtask

    task automatic pushExp();
        exp_t e;
        e = '0;
        if (!rst && owner >= 0) begin
            e.g = N'(1) << owner;
            e.b = 1'b1;
            e.d = dat[owner*32 +: 32];
            if (req[owner] && vld[owner] && !full) begin
                e.a = e.g;
                e.v = 1'b1;
                dataQ.push_back(e.d);
            end
        end
        expQ.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic [N-1:0] rq, input logic [N-1:0] vl,
                         input logic [N-1:0] ls, input logic f);
        @(posedge clk);
        #1;
        modelStep();
        rst  = r;
        req  = rq;
        vld  = vl;
        lst  = ls;
        full = f;
        for (int k = 0; k < N; k++) dat[k*32 +: 32] = $urandom;
        if (rst) begin
            owner = -1; ptr = 0; words = 0;
        end
        pushExp();
    endtask

    task automatic idle2();
        cycle(0, '0, '0, '0, 0);
        cycle(0, '0, '0, '0, 0);
    endtask

    // Monitor: per-cycle output comparison plus in-order FIFO write scoreboard.
    initial begin
        exp_t        e;
        logic [31:0] d;
        logic [N-1:0] prevG;
        int          bw, idleCnt;
        prevG = '0; bw = 0; idleCnt = 0;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                total++;
                if ({o_grant, o_accept, o_busy, o_fifoDataValid, o_fifoData} !== e) begin
                    bad++;
                    $display("FAIL outputs: got g=%b a=%b busy=%b v=%b d=%h want g=%b a=%b busy=%b v=%b d=%h at %0t",
                             o_grant, o_accept, o_busy, o_fifoDataValid, o_fifoData,
                             e.g, e.a, e.b, e.v, e.d, $time);
                end
            end
            if (o_fifoDataValid === 1'b1) begin
                total++;
                if (dataQ.size() == 0) begin
                    bad++;
                    $display("FAIL fifo write: got unexpected word %h want none at %0t", o_fifoData, $time);
                end else begin
                    d = dataQ.pop_front();
                    if (o_fifoData !== d) begin
                        bad++;
                        $display("FAIL fifo data: got %h want %h at %0t", o_fifoData, d, $time);
                    end
                end
            end
            if (logB) begin
                if (o_grant != '0 && prevG == '0) begin
                    for (int k = 0; k < N; k++) if (o_grant[k]) obsOwners.push_back(k);
                    if (obsLens.size() > 0) obsGaps.push_back(idleCnt);
                    bw = 0;
                end
                if (o_grant != '0 && o_fifoDataValid) bw++;
                if (o_grant == '0 && prevG != '0) begin
                    obsLens.push_back(bw);
                    idleCnt = 1;
                end else if (o_grant == '0) begin
                    idleCnt++;
                end
            end
            prevG = o_grant;
        end
    end

    initial begin
        rst = 1'b1; req = '0; vld = '0; lst = '0; full = 1'b0; dat = '0;

        // Requester 2 alone, five words, last on the fifth; then pointer must sit at 3.
        cycle(1, '0, '0, '0, 0);
        idle2();
        check("reset grant", {60'd0, o_grant}, 64'd0);
        cycle(0, 4'b0100, 4'b0000, '0, 0);
        for (int w = 1; w <= 5; w++) begin
            cycle(0, 4'b0100, 4'b0100, (w == 5) ? 4'b0100 : 4'b0000, 0);
            if (w == 1) check("grant r2", {60'd0, o_grant}, 64'h4);
        end
        cycle(0, 4'b1111, 4'b0000, '0, 0);
        cycle(0, '0, '0, '0, 0);
        check("pointer after r2", {60'd0, o_grant}, 64'h8);
        idle2();

        // Requester 0 with a four-cycle FIFO-full stall mid-burst.
        for (int i = 0; i < 24; i++) cycle(0, 4'b0001, 4'b0001, '0, (i >= 5 && i < 9));
        idle2();

        // Requester 1 drops request after three words; pointer moves to 2.
        cycle(0, 4'b0010, 4'b0000, '0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 4'b0010, 4'b0010, '0, 0);
        cycle(0, '0, '0, '0, 0);
        cycle(0, 4'b1111, 4'b0000, '0, 0);
        cycle(0, '0, '0, '0, 0);
        check("pointer after drop", {60'd0, o_grant}, 64'h4);
        idle2();

        // Requester 3 asserts last while full; burst must continue.
        for (int i = 0; i < 14; i++) begin
            cycle(0, 4'b1000, 4'b1000, (i == 4 || i == 9) ? 4'b1000 : 4'b0000, (i == 4));
            if (i == 6) check("busy after full last", {63'd0, o_busy}, 64'd1);
        end
        idle2();

        // Reset pulsed mid-burst: outputs clear at once, lowest index wins next.
        cycle(0, 4'b0010, 4'b0010, '0, 0);
        for (int i = 0; i < 20 && words < 5; i++) cycle(0, 4'b0010, 4'b0010, '0, 0);
        cycle(1, 4'b1111, 4'b1111, '0, 0);
        #1;
        check("async reset outputs", {21'd0, o_grant, o_accept, o_busy, o_fifoDataValid, o_fifoData}, 64'd0);
        cycle(1, 4'b1111, 4'b1111, '0, 0);
        cycle(0, 4'b1111, 4'b1111, '0, 0);
        cycle(0, 4'b1111, 4'b1111, '0, 0);
        check("grant after reset", {60'd0, o_grant}, 64'h1);
        idle2();

        // All four requesting continuously: fair rotation, full bursts, one idle gap.
        cycle(1, '0, '0, '0, 0);
        cycle(0, '0, '0, '0, 0);
        logB = 1'b1;
        for (int i = 0; i < 90; i++) cycle(0, 4'b1111, 4'b1111, '0, 0);
        logB = 1'b0;
        idle2();
        check("rotation count", {63'd0, obsOwners.size() >= 5}, 64'd1);
        for (int i = 0; i < 5; i++)
            check("rotation owner", (i < obsOwners.size()) ? 64'(obsOwners[i]) : 64'hFFFF, 64'(i % N));
        for (int i = 0; i < 4; i++) begin
            check("burst length", (i < obsLens.size()) ? 64'(obsLens[i]) : 64'hFFFF, 64'(MAXB));
            check("idle gap", (i < obsGaps.size()) ? 64'(obsGaps[i]) : 64'hFFFF, 64'd1);
        end

        // Randomised traffic with sticky requests, stalls and rare resets.
        for (int c = 0; c < 2500; c++) begin
            logic [N-1:0] rq, vl, ls;
            logic         f, r;
            rq = req;
            for (int k = 0; k < N; k++) begin
                if (rq[k]) begin
                    if ($urandom_range(15) == 0) rq[k] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    rq[k] = 1'b1;
                end
            end
            vl = N'($urandom | $urandom);
            ls = N'($urandom & $urandom & $urandom);
            f  = ($urandom_range(4) == 0);
            r  = ($urandom_range(399) == 0);
            cycle(r, rq, vl, ls, f);
        end
        cycle(0, '0, '0, '0, 0);
        idle2();
        @(negedge clk);
        #1;
        check("expectations drained", 64'(expQ.size()), 64'd0);
        check("writes drained", 64'(dataQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
